// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - video timing in / pixel out bundle for the pattern generator
interface vga_pattern_gen_if;
    logic        in_hs;
    logic        in_vs;
    logic        in_de;
    logic [10:0] in_x;
    logic [10:0] in_y;
    logic        out_hs;
    logic        out_vs;
    logic        out_de;
    logic [7:0]  out_r;
    logic [7:0]  out_g;
    logic [7:0]  out_b;

    modport master (
        output in_hs, in_vs, in_de, in_x, in_y,
        input  out_hs, out_vs, out_de, out_r, out_g, out_b
    );

    modport slave (
        input  in_hs, in_vs, in_de, in_x, in_y,
        output out_hs, out_vs, out_de, out_r, out_g, out_b
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - four-pattern test pixel source with 2-cycle timing-aligned output
module vga_pattern_gen #(
    parameter logic [10:0] H_ACTIVE  = 11'd1920,
    parameter logic [10:0] V_ACTIVE  = 11'd1080,
    parameter logic [10:0] BOX_SIZE  = 11'd64,
    parameter logic [10:0] BOX_STEP  = 11'd4,
    parameter logic [10:0] BAR_WIDTH = 11'd240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    output logic [7:0]  frame_cnt,
    vga_pattern_gen_if.slave vid
);
    logic        vs_d;
    logic        frame_tick;
    logic [1:0]  mode_q;
    logic [10:0] box_x;
    logic [10:0] box_y;
    logic        dir_x;
    logic        dir_y;
    logic [11:0] next_x;
    logic [11:0] next_y;

    logic        s1_hs;
    logic        s1_vs;
    logic        s1_de;
    logic [23:0] s1_rgb;

    logic [23:0] bar_rgb;
    logic [23:0] pix_rgb;
    logic        in_box;

    assign frame_tick = vs_d & ~vid.in_vs;

    // Returns {new_dir, new_pos}; dir 1 means moving towards larger coordinates.
    function automatic logic [11:0] box_next(input logic [10:0] pos, input logic dir,
                                             input logic [10:0] limit);
        logic [11:0] reach;
        reach = {1'b0, pos} + {1'b0, BOX_STEP} + {1'b0, BOX_SIZE};
        if (dir && (reach > {1'b0, limit}))
            box_next = {1'b0, limit - BOX_SIZE};
        else if (!dir && (pos < BOX_STEP))
            box_next = {1'b1, 11'd0};
        else if (dir)
            box_next = {1'b1, pos + BOX_STEP};
        else
            box_next = {1'b0, pos - BOX_STEP};
    endfunction

    assign next_x = box_next(box_x, dir_x, H_ACTIVE);
    assign next_y = box_next(box_y, dir_y, V_ACTIVE);

    // Bar index by comparator ladder so no divider is needed.
    always_comb begin
        bar_rgb = 24'h000000;
        if (vid.in_x < BAR_WIDTH)                 bar_rgb = 24'hFFFFFF;
        else if (vid.in_x < BAR_WIDTH * 11'd2)    bar_rgb = 24'hFFFF00;
        else if (vid.in_x < BAR_WIDTH * 11'd3)    bar_rgb = 24'h00FFFF;
        else if (vid.in_x < BAR_WIDTH * 11'd4)    bar_rgb = 24'h00FF00;
        else if (vid.in_x < BAR_WIDTH * 11'd5)    bar_rgb = 24'hFF00FF;
        else if (vid.in_x < BAR_WIDTH * 11'd6)    bar_rgb = 24'hFF0000;
        else if (vid.in_x < BAR_WIDTH * 11'd7)    bar_rgb = 24'h0000FF;
    end

    assign in_box = ({1'b0, vid.in_x} >= {1'b0, box_x}) &
                    ({1'b0, vid.in_x} <  ({1'b0, box_x} + {1'b0, BOX_SIZE})) &
                    ({1'b0, vid.in_y} >= {1'b0, box_y}) &
                    ({1'b0, vid.in_y} <  ({1'b0, box_y} + {1'b0, BOX_SIZE}));

    always_comb begin
        pix_rgb = 24'h000000;
        case (mode_q)
            2'd0: pix_rgb = bar_rgb;
            2'd1: pix_rgb = (vid.in_x[6] ^ vid.in_y[6]) ? 24'hFFFFFF : 24'h000000;
            2'd2: pix_rgb = {vid.in_x[10:3], vid.in_y[10:3], frame_cnt};
            default: pix_rgb = in_box ? 24'hFFFFFF : 24'h000040;
        endcase
    end

    // Frame-rate state; a pixel coinciding with a tick still sees the old box and mode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vs_d      <= 1'b0;
            frame_cnt <= 8'd0;
            mode_q    <= 2'd0;
            box_x     <= 11'd0;
            box_y     <= 11'd0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
        end else begin
            vs_d <= vid.in_vs;
            if (frame_tick) begin
                frame_cnt <= frame_cnt + 8'd1;
                mode_q    <= mode;
                {dir_x, box_x} <= next_x;
                {dir_y, box_y} <= next_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_hs      <= 1'b1;
            s1_vs      <= 1'b1;
            s1_de      <= 1'b0;
            s1_rgb     <= 24'h000000;
            vid.out_hs <= 1'b1;
            vid.out_vs <= 1'b1;
            vid.out_de <= 1'b0;
            vid.out_r  <= 8'd0;
            vid.out_g  <= 8'd0;
            vid.out_b  <= 8'd0;
        end else begin
            s1_hs      <= vid.in_hs;
            s1_vs      <= vid.in_vs;
            s1_de      <= vid.in_de;
            s1_rgb     <= pix_rgb;
            vid.out_hs <= s1_hs;
            vid.out_vs <= s1_vs;
            vid.out_de <= s1_de;
            {vid.out_r, vid.out_g, vid.out_b} <= s1_de ? s1_rgb : 24'h000000;
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - directed self-checking bench for vga_pattern_gen
module tb_vga_pattern_gen;
    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic [7:0] frame_cnt;

    int tests;
    int fails;

    logic [10:0] m_bx;
    logic [10:0] m_by;
    logic        m_dx;
    logic        m_dy;
    logic [7:0]  m_fc;

    vga_pattern_gen_if vif ();

    vga_pattern_gen dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .frame_cnt (frame_cnt),
        .vid       (vif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        vif.in_hs = 1'b1;
        vif.in_vs = 1'b1;
        vif.in_de = 1'b0;
        vif.in_x  = 11'd0;
        vif.in_y  = 11'd0;
    endtask

    task automatic model_reset();
        m_bx = 11'd0;
        m_by = 11'd0;
        m_dx = 1'b1;
        m_dy = 1'b1;
        m_fc = 8'd0;
    endtask

    task automatic model_tick();
        m_fc = m_fc + 8'd1;
        if (m_dx) begin
            if (int'(m_bx) + 68 > 1920) begin m_bx = 11'd1856; m_dx = 1'b0; end
            else m_bx = m_bx + 11'd4;
        end else if (m_bx < 11'd4) begin
            m_bx = 11'd0; m_dx = 1'b1;
        end else m_bx = m_bx - 11'd4;
        if (m_dy) begin
            if (int'(m_by) + 68 > 1080) begin m_by = 11'd1016; m_dy = 1'b0; end
            else m_by = m_by + 11'd4;
        end else if (m_by < 11'd4) begin
            m_by = 11'd0; m_dy = 1'b1;
        end else m_by = m_by - 11'd4;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        vif.in_vs = 1'b0;
        vif.in_de = 1'b0;
        @(posedge clk);
        #1;
        model_tick();
        @(posedge clk);
        #1;
        vif.in_vs = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic get_pix(input logic [10:0] x, input logic [10:0] y, output logic [24:0] obs);
        vif.in_de = 1'b1;
        vif.in_x  = x;
        vif.in_y  = y;
        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        #1;
        obs = {vif.out_de, vif.out_r, vif.out_g, vif.out_b};
    endtask

    task automatic test_reset();
        logic [34:0] obs;
        rst  = 1'b0;
        mode = 2'd0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            obs = {vif.out_hs, vif.out_vs, vif.out_de, vif.out_r, vif.out_g, vif.out_b, frame_cnt};
            tests++;
            if (obs !== {3'b110, 24'h000000, 8'd0}) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: got %h expected %h", i, obs, {3'b110, 24'h0, 8'd0});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_bars();
        logic [10:0] xs [5];
        logic        hs [5];
        logic [23:0] ex [5];
        logic [26:0] obs;
        xs = '{11'd0, 11'd239, 11'd240, 11'd1679, 11'd1919};
        hs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ex = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h0000FF, 24'h000000};
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                vif.in_de = 1'b1;
                vif.in_hs = hs[i];
                vif.in_x  = xs[i];
                vif.in_y  = 11'd10;
            end else idle_inputs();
            @(posedge clk);
            #1;
            if (i >= 1) begin
                obs = {vif.out_hs, vif.out_vs, vif.out_de, vif.out_r, vif.out_g, vif.out_b};
                tests++;
                if (obs !== {hs[i-1], 2'b11, ex[i-1]}) begin
                    fails++;
                    $display("FAIL bars x=%0d: got %h expected %h", xs[i-1], obs, {hs[i-1], 2'b11, ex[i-1]});
                end
            end
        end
    endtask

    task automatic test_checker();
        logic [10:0] xs [4];
        logic [10:0] ys [4];
        logic [23:0] ex [4];
        logic [24:0] obs;
        mode = 2'd1;
        vsync_pulse();
        tests++;
        if (frame_cnt !== m_fc) begin
            fails++;
            $display("FAIL checker_frame_cnt: got %0d expected %0d", frame_cnt, m_fc);
        end
        xs = '{11'd64, 11'd64, 11'd0, 11'd0};
        ys = '{11'd0, 11'd64, 11'd0, 11'd64};
        ex = '{24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF};
        for (int i = 0; i < 4; i++) begin
            get_pix(xs[i], ys[i], obs);
            tests++;
            if (obs !== {1'b1, ex[i]}) begin
                fails++;
                $display("FAIL checker (%0d,%0d): got %h expected %h", xs[i], ys[i], obs, {1'b1, ex[i]});
            end
        end
    endtask

    task automatic test_box();
        logic [10:0] xs [5];
        logic [10:0] ys [5];
        logic [23:0] ex [5];
        logic [24:0] obs;
        apply_reset();
        mode = 2'd3;
        repeat (3) vsync_pulse();
        tests++;
        if (frame_cnt !== 8'd3) begin
            fails++;
            $display("FAIL box_frame_cnt: got %0d expected 3", frame_cnt);
        end
        xs = '{11'd12, 11'd11, 11'd75, 11'd76, 11'd12};
        ys = '{11'd12, 11'd12, 11'd75, 11'd12, 11'd76};
        ex = '{24'hFFFFFF, 24'h000040, 24'hFFFFFF, 24'h000040, 24'h000040};
        for (int i = 0; i < 5; i++) begin
            get_pix(xs[i], ys[i], obs);
            tests++;
            if (obs !== {1'b1, ex[i]}) begin
                fails++;
                $display("FAIL box (%0d,%0d): got %h expected %h", xs[i], ys[i], obs, {1'b1, ex[i]});
            end
        end
    endtask

    task automatic test_box_wrap();
        logic [24:0] obs;
        logic [10:0] px;
        logic [10:0] py;
        for (int f = 0; f < 1000; f++) begin
            vsync_pulse();
            tests++;
            if (frame_cnt !== m_fc) begin
                fails++;
                $display("FAIL wrap_frame_cnt frame %0d: got %0d expected %0d", f, frame_cnt, m_fc);
            end
            get_pix(m_bx, m_by, obs);
            tests++;
            if (obs !== {1'b1, 24'hFFFFFF}) begin
                fails++;
                $display("FAIL wrap_corner frame %0d (%0d,%0d): got %h expected %h", f, m_bx, m_by, obs, {1'b1, 24'hFFFFFF});
            end
            get_pix(m_bx + 11'd63, m_by + 11'd63, obs);
            tests++;
            if (obs !== {1'b1, 24'hFFFFFF}) begin
                fails++;
                $display("FAIL wrap_far_corner frame %0d (%0d,%0d): got %h expected %h", f, m_bx, m_by, obs, {1'b1, 24'hFFFFFF});
            end
            if (int'(m_bx) + 64 < 1920) begin px = m_bx + 11'd64; py = m_by + 11'd63; end
            else begin px = m_bx - 11'd1; py = m_by; end
            get_pix(px, py, obs);
            tests++;
            if (obs !== {1'b1, 24'h000040}) begin
                fails++;
                $display("FAIL wrap_outside frame %0d (%0d,%0d): got %h expected %h", f, px, py, obs, {1'b1, 24'h000040});
            end
        end
    endtask

    task automatic test_mode_change();
        logic [24:0] obs;
        mode = 2'd0;
        vsync_pulse();
        get_pix(11'd300, 11'd5, obs);
        tests++;
        if (obs !== {1'b1, 24'hFFFF00}) begin
            fails++;
            $display("FAIL mode_bars_before: got %h expected %h", obs, {1'b1, 24'hFFFF00});
        end
        mode = 2'd2;
        get_pix(11'd1000, 11'd5, obs);
        tests++;
        if (obs !== {1'b1, 24'hFF00FF}) begin
            fails++;
            $display("FAIL mode_bars_held: got %h expected %h", obs, {1'b1, 24'hFF00FF});
        end
        vsync_pulse();
        get_pix(11'd80, 11'd16, obs);
        tests++;
        if (obs !== {1'b1, 8'd10, 8'd2, m_fc}) begin
            fails++;
            $display("FAIL mode_gradient_a: got %h expected %h", obs, {1'b1, 8'd10, 8'd2, m_fc});
        end
        get_pix(11'd1919, 11'd1079, obs);
        tests++;
        if (obs !== {1'b1, 8'd239, 8'd134, m_fc}) begin
            fails++;
            $display("FAIL mode_gradient_b: got %h expected %h", obs, {1'b1, 8'd239, 8'd134, m_fc});
        end
    endtask

    task automatic test_midline_reset();
        logic [34:0] obs;
        logic [24:0] pix;
        vif.in_de = 1'b1;
        vif.in_hs = 1'b0;
        vif.in_x  = 11'd500;
        vif.in_y  = 11'd40;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({vif.out_hs, vif.out_de} !== 2'b01) begin
            fails++;
            $display("FAIL midline_pre: got hs/de %b expected 01", {vif.out_hs, vif.out_de});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        obs = {vif.out_hs, vif.out_vs, vif.out_de, vif.out_r, vif.out_g, vif.out_b, frame_cnt};
        tests++;
        if (obs !== {3'b110, 24'h000000, 8'd0}) begin
            fails++;
            $display("FAIL midline_reset: got %h expected %h", obs, {3'b110, 24'h0, 8'd0});
        end
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        get_pix(11'd0, 11'd0, pix);
        tests++;
        if (pix !== {1'b1, 24'hFFFFFF}) begin
            fails++;
            $display("FAIL midline_resume: got %h expected %h", pix, {1'b1, 24'hFFFFFF});
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        mode  = 2'd0;
        idle_inputs();
        model_reset();
        test_reset();
        test_bars();
        test_checker();
        test_box();
        test_box_wrap();
        test_mode_change();
        test_midline_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
